spi_cmd_decoder: RTL and testbench
==================================

Name: spi_cmd_decoder

Overview:
- Sits directly downstream of the SPI byte-level slave in the robot FPGA.
- Consumes the received-byte strobe and byte from the slave, frames transactions using chip select, decodes a command byte, and performs auto-incrementing register reads and writes on a simple register bus.
- Supplies the slave's next transmit byte, which is either a status byte or read data.

Parameters:
- ADDR_W, 7, register address width; the address comes from command byte bits [ADDR_W-1:0], and ADDR_W must be ≤ 7.
- STATUS_BYTE, 8'hA5, byte returned to the master while the command byte is being shifted in.
- AUTO_INC, 1, when 1 the address increments after each data byte; when 0 the address is held.

Ports:
- clk  in  1  system clock; the same clock that drives the SPI slave.
- rst  in  1  asynchronous, active-high reset.
- ncs  in  1  raw SPI chip select, active low; asynchronous to clk.
- byte_done  in  1  slave transfer-done flag; treated as a level, and only its rising edge is used.
- byte_in  in  8  byte received by the slave, valid when byte_done rises.
- byte_out  out  8  next byte for the slave to transmit; connects to the slave's din.
- reg_addr  out  ADDR_W  register bus address.
- reg_wdata  out  8  register write data.
- reg_we  out  1  write strobe, one clk wide.
- reg_re  out  1  read strobe, one clk wide.
- reg_rdata  in  8  read data, valid exactly 1 clk after reg_re.
- busy  out  1  high while a transaction is framed (synchronised ncs is low).

Behaviour:
- Reset: asynchronous and active-high.
  - byte_out resets to STATUS_BYTE.
  - reg_addr, reg_wdata, reg_we, reg_re and busy reset to 0.
  - State resets to IDLE.
  - The ncs synchroniser resets to 1; the byte_done history register resets to 0.
- ncs synchronisation: a 2-flop synchroniser produces ncs_s.
- Byte strobe: byte_stb = byte_done & ~byte_done_d, with byte_done_d registered each clk. This gives exactly one strobe per received byte.
- busy equals ~ncs_s, registered.
- State IDLE:
  - byte_out holds STATUS_BYTE.
  - Strobes are ignored.
  - On ncs_s falling, go to CMD.
- State CMD: on byte_stb:
  - Latch reg_addr <= byte_in[ADDR_W-1:0].
  - If byte_in[7] = 1, go to READ and pulse reg_re on the next clk.
  - If byte_in[7] = 0, go to WRITE.
- State READ:
  - Read pipeline: reg_rdata is sampled 1 clk after reg_re and registered into byte_out. byte_out is therefore valid at most 3 clk after the command byte_stb, so it is ready well before the next byte boundary.
  - On each byte_stb in READ, the received byte is discarded.
  - If AUTO_INC = 1, reg_addr increments first; then reg_re pulses again and byte_out is refreshed through the same pipeline.
- State WRITE: on byte_stb:
  - reg_wdata <= byte_in, and reg_we pulses for 1 clk the next cycle with the current reg_addr.
  - After the reg_we cycle, reg_addr increments if AUTO_INC = 1.
  - byte_out = STATUS_BYTE throughout WRITE.
- Address wrap: the address increments modulo 2^ADDR_W, so all-ones wraps to 0.
- Transaction end: ncs_s rising in any state returns to IDLE on the next clk.
  - byte_out is restored to STATUS_BYTE.
  - A partially shifted byte produces no strobe and no register access.
  - A reg_we or reg_re pulse already scheduled for the cycle of the ncs_s rise still completes; no new pulse is issued after it.
- Simultaneous events: if byte_stb and ncs_s rising coincide, the strobe is processed first, so a write completes, and then the block returns to IDLE.
- Strobe outside a transaction: a byte_stb while in IDLE (noise, or ncs not yet synchronised) is ignored.
- Pulse exclusivity: reg_we and reg_re are never asserted in the same cycle.
- Mid-operation reset: reset asserted mid-transaction forces the reset values immediately. After reset deasserts with ncs still low, the block waits in IDLE for a fresh ncs falling edge.

Test Plan:
- Reset values: assert rst -> byte_out = 8'hA5, reg_we = reg_re = 0, busy = 0. Then drop ncs -> busy = 1 within 3 clk.
- Burst write: ncs low, bytes 0x05, 0x11, 0x22 -> reg_we pulses twice, at addr 5 with data 0x11 and at addr 6 with data 0x22. byte_out stays 0xA5.
- Burst read: model reg_rdata = addr + 0x40; ncs low, bytes 0x83, 0x00, 0x00 -> byte_out = 0x43 within 3 clk of the first strobe, then 0x44, then 0x45. reg_re pulses 3 times.
- Address wrap: write command 0x7F followed by 2 data bytes -> writes land at addr 0x7F, then addr 0x00.
- Abort: ncs rises after 4 SCK bits of a data byte -> no reg_we, state returns to IDLE, byte_out = 0xA5. The next transaction decodes its first byte as a command.
- Edge handling: byte_done held high for 10 clk -> exactly one register access. Also, a strobe coincident with ncs rising in WRITE -> the write is performed, then the block returns to IDLE.

Source files
------------

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: frames bytes by chip select and runs auto-incrementing register reads/writes.
// States: IDLE (wait for fresh ncs fall) | CMD (decode command) | READ (prefetch read data) | WRITE (store data).
module spi_cmd_decoder #(
  parameter int unsigned ADDR_W      = 7,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5,
  parameter bit          AUTO_INC    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ncs,
  input  logic              byte_done,
  input  logic [7:0]        byte_in,
  output logic [7:0]        byte_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_READ, S_WRITE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              ncs_m_q, ncs_m_d;
  logic              ncs_s_q, ncs_s_d;
  logic [1:0]        vld_q, vld_d;
  logic              armed_q, armed_d;
  logic              byte_done_q, byte_done_d;
  logic              rd_pend_q, rd_pend_d;
  logic [7:0]        byte_out_q, byte_out_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              busy_q, busy_d;
  logic              byte_stb;

  always_comb begin
    state_d     = state_q;
    ncs_m_d     = ncs;
    ncs_s_d     = ncs_m_q;
    vld_d       = {vld_q[0], 1'b1};
    armed_d     = armed_q;
    byte_done_d = byte_done;
    rd_pend_d   = reg_re_q;
    byte_out_d  = byte_out_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = ~ncs_s_q;
    byte_stb    = byte_done & ~byte_done_q;

    if (AUTO_INC && reg_we_q)
      reg_addr_d = reg_addr_q + ADDR_ONE;

    case (state_q)
      S_IDLE: begin
        byte_out_d = STATUS_BYTE;
        // Arm only once a genuine high ncs has passed the synchroniser, so ncs
        // held low across reset does not look like a new transaction.
        armed_d = armed_q | (vld_q[1] & ncs_s_q);
        if (armed_q && !ncs_s_q) begin
          state_d = S_CMD;
          armed_d = 1'b0;
        end
      end
      S_CMD: begin
        byte_out_d = STATUS_BYTE;
        if (byte_stb) begin
          reg_addr_d = byte_in[ADDR_W-1:0];
          if (byte_in[7]) begin
            state_d  = S_READ;
            reg_re_d = 1'b1;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_READ: begin
        if (rd_pend_q)
          byte_out_d = reg_rdata;
        if (byte_stb) begin
          if (AUTO_INC)
            reg_addr_d = reg_addr_q + ADDR_ONE;
          reg_re_d = 1'b1;
        end
      end
      S_WRITE: begin
        byte_out_d = STATUS_BYTE;
        if (byte_stb) begin
          reg_wdata_d = byte_in;
          reg_we_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A strobe in the same cycle is still honoured above before leaving.
    if (state_q != S_IDLE && ncs_s_q) begin
      state_d    = S_IDLE;
      byte_out_d = STATUS_BYTE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ncs_m_q     <= 1'b1;
      ncs_s_q     <= 1'b1;
      vld_q       <= 2'b00;
      armed_q     <= 1'b0;
      byte_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      byte_out_q  <= STATUS_BYTE;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ncs_m_q     <= ncs_m_d;
      ncs_s_q     <= ncs_s_d;
      vld_q       <= vld_d;
      armed_q     <= armed_d;
      byte_done_q <= byte_done_d;
      rd_pend_q   <= rd_pend_d;
      byte_out_q  <= byte_out_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
    end
  end

  assign byte_out  = byte_out_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: directed edge cases plus random transactions checked
// against an access list computed from the command/address rules.
module tb_spi_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ncs = 1'b1;
  logic       byte_done = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic [7:0] byte_out;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int both_cnt = 0;

  logic [14:0] wlog[$];
  logic [6:0]  rlog[$];
  logic [7:0]  tx[0:7];

  spi_cmd_decoder #(.ADDR_W(7), .STATUS_BYTE(8'hA5), .AUTO_INC(1'b1)) dut (
    .clk(clk), .rst(rst), .ncs(ncs), .byte_done(byte_done), .byte_in(byte_in),
    .byte_out(byte_out), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register-bus model: data is addr+0x40, valid only the cycle after reg_re.
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= {1'b0, reg_addr} + 8'h40;
    else        reg_rdata <= 8'hEE;
    if (!rst) begin
      if (reg_we) wlog.push_back({reg_addr, reg_wdata});
      if (reg_re) rlog.push_back(reg_addr);
      if (reg_we && reg_re) both_cnt <= both_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] seen);
    byte_in   = b;
    byte_done = 1'b1;
    tick(3);
    seen      = byte_out;
    byte_done = 1'b0;
    tick(5);
  endtask

  task automatic clear_logs();
    wlog.delete();
    rlog.delete();
  endtask

  // Full transaction tx[0..n-1]; expectations follow from the command byte alone.
  task automatic do_txn(input int n);
    logic [7:0] seen;
    int a;
    a = int'(tx[0][6:0]);
    clear_logs();
    ncs = 1'b0;
    tick(4);
    chk("busy_in_txn", busy, 1);
    for (int i = 0; i < n; i++) begin
      send_byte(tx[i], seen);
      if (tx[0][7]) chk("rd_byte_out", seen, ((a + i) % 128) + 8'h40);
      else          chk("wr_byte_out", seen, 8'hA5);
    end
    ncs = 1'b1;
    tick(6);
    chk("end_byte_out", byte_out, 8'hA5);
    chk("end_busy", busy, 0);
    if (tx[0][7]) begin
      chk("rd_count", rlog.size(), n);
      chk("rd_no_wr", wlog.size(), 0);
      for (int i = 0; i < n && i < rlog.size(); i++)
        chk("rd_addr", rlog[i], (a + i) % 128);
    end else begin
      chk("wr_count", wlog.size(), n - 1);
      chk("wr_no_rd", rlog.size(), 0);
      for (int i = 1; i < n && i - 1 < wlog.size(); i++)
        chk("wr_access", wlog[i-1], {7'((a + i - 1) % 128), tx[i]});
    end
  endtask

  initial begin
    logic [7:0] seen;
    int n;

    // Reset values
    tick(3);
    chk("rst_byte_out", byte_out, 8'hA5);
    chk("rst_we", reg_we, 0);
    chk("rst_re", reg_re, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", reg_addr, 0);
    rst = 1'b0;
    tick(4);
    ncs = 1'b0;
    tick(3);
    chk("busy_3clk", busy, 1);
    ncs = 1'b1;
    tick(6);

    // Burst write
    tx[0] = 8'h05; tx[1] = 8'h11; tx[2] = 8'h22;
    do_txn(3);

    // Burst read, first data within 3 clk of the command strobe
    tx[0] = 8'h83; tx[1] = 8'h00; tx[2] = 8'h00;
    do_txn(3);

    // Address wrap
    tx[0] = 8'h7F; tx[1] = 8'hC3; tx[2] = 8'h3C;
    do_txn(3);

    // Abort mid data byte: no strobe arrives before ncs rises
    clear_logs();
    ncs = 1'b0;
    tick(4);
    send_byte(8'h10, seen);
    tick(2);
    ncs = 1'b1;
    tick(6);
    chk("abort_no_wr", wlog.size(), 0);
    chk("abort_byte_out", byte_out, 8'hA5);
    tx[0] = 8'h85; tx[1] = 8'h10;
    do_txn(2);

    // byte_done held high for 10 clk gives one access
    clear_logs();
    ncs = 1'b0;
    tick(4);
    send_byte(8'h20, seen);
    byte_in = 8'h99;
    byte_done = 1'b1;
    tick(10);
    byte_done = 1'b0;
    tick(4);
    ncs = 1'b1;
    tick(6);
    chk("hold_wr_count", wlog.size(), 1);
    if (wlog.size() > 0) chk("hold_wr", wlog[0], {7'h20, 8'h99});

    // Strobe coincident with synchronised ncs rising in WRITE
    clear_logs();
    ncs = 1'b0;
    tick(4);
    send_byte(8'h31, seen);
    ncs = 1'b1;
    tick(2);
    byte_in = 8'h77;
    byte_done = 1'b1;
    tick(1);
    byte_done = 1'b0;
    tick(6);
    chk("coinc_wr_count", wlog.size(), 1);
    if (wlog.size() > 0) chk("coinc_wr", wlog[0], {7'h31, 8'h77});
    chk("coinc_byte_out", byte_out, 8'hA5);
    tx[0] = 8'h8A; tx[1] = 8'h00;
    do_txn(2);

    // Reset mid-transaction with ncs held low: block must wait for a new fall
    clear_logs();
    ncs = 1'b0;
    tick(4);
    send_byte(8'h8C, seen);
    rst = 1'b1;
    #1;
    chk("midrst_byte_out", byte_out, 8'hA5);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", reg_addr, 0);
    tick(2);
    rst = 1'b0;
    tick(4);
    clear_logs();
    send_byte(8'h44, seen);
    send_byte(8'h55, seen);
    chk("midrst_no_wr", wlog.size(), 0);
    chk("midrst_no_rd", rlog.size(), 0);
    chk("midrst_out", seen, 8'hA5);
    ncs = 1'b1;
    tick(6);
    tx[0] = 8'h12; tx[1] = 8'h5A;
    do_txn(2);

    // Random transactions
    for (int t = 0; t < 25; t++) begin
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < 8; i++) tx[i] = 8'($urandom);
      do_txn(n);
    end

    chk("pulse_exclusive", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
